// File: rtl/distribuidor_papeis.sv
// rtl/distribuidor_papeis.sv - deals werewolf/seer roles to 8 players from an LFSR-driven candidate stream.
// Optional seer stage is built when the macro VIDENTE_EN is defined.
module distribuidor_papeis #(
  parameter int N_LOBOS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicia,
  input  logic [7:0] seed,
  input  logic [2:0] consulta_idx,
  output logic [1:0] papel,
  output logic [7:0] mascara_lobos,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    LIMPA           = 3'd1,
    SORTEIA_LOBO    = 3'd2,
    SORTEIA_VIDENTE = 3'd3,
    PRONTO          = 3'd4
  } estado_t;

  localparam logic [1:0] ALDEAO = 2'd0;
  localparam logic [1:0] LOBO   = 2'd1;
`ifdef VIDENTE_EN
  localparam logic [1:0] VIDENTE = 2'd2;
`endif
  localparam logic [2:0] ULTIMO_LOBO = 3'(N_LOBOS - 1);

  estado_t    estado;
  estado_t    estado_n;
  logic [1:0] papeis [8];
  logic [2:0] cont_lobos;
  logic [7:0] lfsr;
  logic [7:0] lfsr_prox;
  logic [2:0] candidato;
  logic       livre;

  assign lfsr_prox = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign candidato = lfsr[2:0];
  assign livre     = (papeis[candidato] == ALDEAO);

  assign papel = papeis[consulta_idx];

  always_comb begin
    mascara_lobos = '0;
    for (int i = 0; i < 8; i++) begin
      mascara_lobos[i] = (papeis[i] == LOBO);
    end
  end

  always_comb begin
    estado_n = estado;
    case (estado)
      OCIOSO: if (inicia) estado_n = LIMPA;
      LIMPA:  estado_n = SORTEIA_LOBO;
      SORTEIA_LOBO: begin
        // Leave on the very cycle the last werewolf is written.
        if (livre && cont_lobos == ULTIMO_LOBO) begin
`ifdef VIDENTE_EN
          estado_n = SORTEIA_VIDENTE;
`else
          estado_n = PRONTO;
`endif
        end
      end
`ifdef VIDENTE_EN
      SORTEIA_VIDENTE: if (livre) estado_n = PRONTO;
`endif
      PRONTO: if (inicia) estado_n = LIMPA;
      default: estado_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      cont_lobos <= '0;
      lfsr       <= 8'h01;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
      db_estado  <= 3'd0;
      for (int i = 0; i < 8; i++) papeis[i] <= ALDEAO;
    end else begin
      estado    <= estado_n;
      pronto    <= (estado_n == PRONTO);
      ocupado   <= (estado_n == LIMPA) || (estado_n == SORTEIA_LOBO) ||
                   (estado_n == SORTEIA_VIDENTE);
      db_estado <= estado_n;
      case (estado)
        LIMPA: begin
          for (int i = 0; i < 8; i++) papeis[i] <= ALDEAO;
          cont_lobos <= '0;
          // An all-zero seed would lock the LFSR.
          lfsr       <= (seed == 8'h00) ? 8'h01 : seed;
        end
        SORTEIA_LOBO: begin
          lfsr <= lfsr_prox;
          if (livre) begin
            papeis[candidato] <= LOBO;
            cont_lobos        <= cont_lobos + 3'd1;
          end
        end
`ifdef VIDENTE_EN
        SORTEIA_VIDENTE: begin
          lfsr <= lfsr_prox;
          if (livre) papeis[candidato] <= VIDENTE;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_distribuidor_papeis.sv
// tb/tb_distribuidor_papeis.sv - scoreboard bench for distribuidor_papeis; expectations follow VIDENTE_EN.
module tb_distribuidor_papeis;

  localparam int N = 2;
`ifdef VIDENTE_EN
  localparam int LAT = N + 3;
  localparam bit VID = 1'b1;
`else
  localparam int LAT = N + 2;
  localparam bit VID = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicia = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [2:0] consulta_idx = 3'd0;
  logic [1:0] papel;
  logic [7:0] mascara_lobos;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  distribuidor_papeis #(.N_LOBOS(N)) dut (
    .clock(clock), .reset(reset), .inicia(inicia), .seed(seed),
    .consulta_idx(consulta_idx), .papel(papel), .mascara_lobos(mascara_lobos),
    .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  always #20 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] mask;
    int         vid;
    int         inicio;
    int         lat;
  } exp_t;

  exp_t esperado[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nome, got, exp);
    end
  endtask

  // Monitor: every rising pronto consumes one expected deal.
  initial begin
    logic pronto_q;
    exp_t e;
    logic [1:0] r;
    pronto_q = 1'b0;
    forever begin
      @(negedge clock);
      if (pronto && !pronto_q) begin
        if (esperado.size() == 0) begin
          chk("unexpected_pronto", 32'd1, 32'd0);
        end else begin
          e = esperado.pop_front();
          chk("mascara", {24'd0, mascara_lobos}, {24'd0, e.mask});
          chk("latencia", cyc - e.inicio, e.lat);
          for (int i = 0; i < 8; i++) begin
            consulta_idx = 3'(i);
            #1;
            r = e.mask[i] ? 2'd1 : ((i == e.vid) ? 2'd2 : 2'd0);
            chk($sformatf("papel[%0d]", i), {30'd0, papel}, {30'd0, r});
          end
        end
      end
      pronto_q = pronto;
    end
  end

  task automatic push(input logic [7:0] m, input int v, input int ini, input int lat);
    exp_t e;
    e.mask = m; e.vid = VID ? v : -1; e.inicio = ini; e.lat = lat;
    esperado.push_back(e);
  endtask

  task automatic wait_pronto(input string nome);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (pronto) ok = 1'b1;
    end
    if (!ok) chk({nome, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic deal(input string nome, input logic [7:0] s, input logic [7:0] m,
                      input int v, input int extra);
    @(negedge clock);
    seed = s;
    inicia = 1'b1;
    push(m, v, cyc, LAT + extra);
    @(negedge clock);
    inicia = 1'b0;
    chk({nome, "_limpa_estado"}, {29'd0, db_estado}, 32'd1);
    chk({nome, "_limpa_ocupado"}, {31'd0, ocupado}, 32'd1);
    wait_pronto(nome);
    @(negedge clock);
    chk({nome, "_pronto_hold"}, {29'd0, db_estado}, 32'd4);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_estado", {29'd0, db_estado}, 32'd0);
    chk("rst_mascara", {24'd0, mascara_lobos}, 32'd0);
    chk("rst_pronto", {31'd0, pronto}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);

    deal("seed01", 8'h01, 8'h06, 4, 0);
    deal("seed00", 8'h00, 8'h06, 4, 0);
    deal("seed09", 8'h09, 8'h0A, 7, 0);
    deal("seed01_again", 8'h01, 8'h06, 4, 0);
    // 0x0F yields candidate 7 twice in a row, costing one extra cycle.
    deal("colisao", 8'h0F, 8'hC0, 5, 1);

    // inicia held across the deal: no restart until PRONTO, then a new deal.
    @(negedge clock);
    seed = 8'h09;
    inicia = 1'b1;
    push(8'h0A, 7, cyc, LAT);
    wait_pronto("held1");
    push(8'h0A, 7, cyc, LAT);
    wait_pronto("held2");
    inicia = 1'b0;
    @(negedge clock);
    chk("held_fim_estado", {29'd0, db_estado}, 32'd4);

    // Reset in the middle of SORTEIA_LOBO.
    seed = 8'h01;
    inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_estado", {29'd0, db_estado}, 32'd2);
    chk("mid_mascara", {24'd0, mascara_lobos}, 32'h02);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_estado", {29'd0, db_estado}, 32'd0);
    chk("midrst_mascara", {24'd0, mascara_lobos}, 32'd0);
    chk("midrst_pronto", {31'd0, pronto}, 32'd0);
    chk("midrst_ocupado", {31'd0, ocupado}, 32'd0);

    // Reset wins over inicia in the same cycle.
    inicia = 1'b1;
    @(negedge clock);
    chk("prio_estado", {29'd0, db_estado}, 32'd0);
    reset = 1'b0;
    inicia = 1'b0;
    @(negedge clock);
    chk("prio_ocioso", {29'd0, db_estado}, 32'd0);

    deal("pos_reset", 8'h09, 8'h0A, 7, 0);

    repeat (3) @(negedge clock);
    chk("fila_vazia", esperado.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/distribuidor_papeis.md
DISTRIBUIDOR_PAPEIS -- requirements
Module: distribuidor_papeis

Interface
REQ-001 SHALL have parameter N_LOBOS, default 2, number of werewolves dealt (legal range 1..6).
REQ-002 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inicia  input  1  start request; sampled only in OCIOSO and PRONTO.
REQ-005 SHALL have port seed  input  8  game seed from the control unit's seed register; must be stable while inicia is high.
REQ-006 SHALL have port consulta_idx  input  3  player index for role readout.
REQ-007 SHALL have port papel  output  2  role of player consulta_idx: 0 aldeao, 1 lobo, 2 vidente.
REQ-008 SHALL have port mascara_lobos  output  8  bit i high when player i is lobo.
REQ-009 SHALL have port ocupado  output  1  high while dealing (LIMPA, SORTEIA_LOBO, SORTEIA_VIDENTE).
REQ-010 SHALL have port pronto  output  1  high in PRONTO; roles valid.
REQ-011 SHALL have port db_estado  output  3  encoded current state (OCIOSO=0, LIMPA=1, SORTEIA_LOBO=2, SORTEIA_VIDENTE=3, PRONTO=4).

Function
REQ-012 SHALL fix the player count at 8; role table is 8 x 2-bit registers.
REQ-013 SHALL implement states OCIOSO, LIMPA, SORTEIA_LOBO, SORTEIA_VIDENTE, PRONTO.
REQ-014 OCIOSO: inicia=1 -> LIMPA; otherwise stay.
REQ-015 LIMPA (1 cycle): clear all 8 roles to aldeao, clear lobo counter, load LFSR with seed (8'h00 replaced by 8'h01) -> SORTEIA_LOBO.
REQ-016 LFSR SHALL be 8-bit Fibonacci, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}, advanced every cycle in SORTEIA_LOBO and SORTEIA_VIDENTE, held otherwise.
REQ-017 Candidate index SHALL be the current (pre-advance) LFSR bits [2:0].
REQ-018 SORTEIA_LOBO: candidate aldeao -> write lobo, counter+1; candidate occupied -> no write; counter reaching N_LOBOS -> SORTEIA_VIDENTE in that cycle.
REQ-019 SORTEIA_VIDENTE: candidate aldeao -> write vidente, -> PRONTO; occupied -> stay.
REQ-020 PRONTO: hold roles, pronto=1; inicia=1 -> LIMPA (new deal).
REQ-021 inicia SHALL be ignored in LIMPA, SORTEIA_LOBO, SORTEIA_VIDENTE.
REQ-022 papel and mascara_lobos SHALL be combinational from the role table and valid in every state (all aldeao after reset/LIMPA).
REQ-023 Each slot SHALL be written at most once per deal; final deal SHALL contain exactly N_LOBOS lobos and (with VIDENTE_EN) exactly one vidente.
REQ-024 Minimum latency: inicia cycle -> pronto asserted N_LOBOS+3 cycles later when no collisions occur.

Reset
REQ-025 reset=1 SHALL, at the next rising edge, force OCIOSO, all roles aldeao, counter 0, LFSR 8'h01, pronto=0, ocupado=0, db_estado=0, regardless of current state (including mid-deal).
REQ-026 reset SHALL take priority over inicia in the same cycle.

Configuration
REQ-027 Macro VIDENTE_EN defined: SORTEIA_VIDENTE is used as in REQ-019.
REQ-028 Macro VIDENTE_EN undefined: SORTEIA_LOBO goes directly to PRONTO on reaching N_LOBOS; role code 2 never produced; latency N_LOBOS+2.

Verification
REQ-029 Reset mid-SORTEIA_LOBO -> next cycle db_estado=0, mascara_lobos=8'h00, pronto=0.
REQ-030 N_LOBOS=2, VIDENTE_EN, seed=8'h01, inicia pulse -> lobos at 1,2 (mascara 8'h06), vidente at 4, pronto 5 cycles after inicia.
REQ-031 seed=8'h00 -> identical result to seed=8'h01.
REQ-032 seed=8'h09 -> mascara_lobos=8'h0A, vidente at 7; second inicia from PRONTO with seed=8'h01 -> mascara 8'h06, old roles fully cleared.
REQ-033 Seed chosen so candidate sequence repeats an index -> slot written once, dealing continues, final counts per REQ-023.
REQ-034 inicia held high through whole deal -> no restart until PRONTO; then new deal starts.
